// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
//   sa_state_t    : controller state encoding (IDLE, RUN, DONE)
//   DEFAULT_WIDTH : default operand / sum width in bits
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage : serial_adder_pkg

// File: rtl/FULL_ADDER.sv
// Gate-level 1-bit full adder cell.
// Ports:
//   A, B  : addend bits
//   Cin   : carry in
//   S     : sum bit   = A ^ B ^ Cin
//   Cout  : carry out = A&B | Cin&(A^B)
module FULL_ADDER (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    logic ab_x;
    logic ab_a;
    logic cx_a;

    xor g_x0 (ab_x, A, B);
    xor g_x1 (S, ab_x, Cin);
    and g_a0 (ab_a, A, B);
    and g_a1 (cx_a, ab_x, Cin);
    or  g_o0 (Cout, ab_a, cx_a);

endmodule : FULL_ADDER

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: {cout,sum} = a + b + cin.
// One bit pair per cycle is fed LSB first through a single FULL_ADDER cell;
// the cell's carry is registered and returned as the next bit's carry in.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready high only in IDLE)
//   a, b, cin           : operands and carry into bit 0
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   sum, cout           : registered result, held until the next result
//   busy                : high while an operation is in RUN or DONE
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    sa_state_t        state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_cout;
    logic [WIDTH-1:0] sum_next;
    logic             sum_sr_unused;

    FULL_ADDER u_fa (
        .A    (a_sr[0]),
        .B    (b_sr[0]),
        .Cin  (carry),
        .S    (fa_s),
        .Cout (fa_cout)
    );

    // New sum bit enters at the top; after WIDTH shifts bit 0 of the
    // operands has travelled down to sum[0]. The oldest bit of sum_sr
    // falls off the bottom and is never needed.
    assign sum_next      = {fa_s, sum_sr[WIDTH-1:1]};
    assign sum_sr_unused = sum_sr[0];

    assign in_ready = (state == IDLE) && !rst;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            sum_sr    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        carry  <= cin;
                        cnt    <= '0;
                        sum_sr <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    sum_sr <= sum_next;
                    carry  <= fa_cout;
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    if (cnt == LAST_BIT) begin
                        // Capture the finished result directly so sum/cout
                        // are valid in the first DONE cycle and persist
                        // after the handshake completes.
                        sum       <= sum_next;
                        cout      <= fa_cout;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): reset state, table of
// directed additions, latency, backpressure, reset mid-run and a randomized
// regression scored against plain integer addition.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vcin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Offer one operand pair, wait for acceptance, then count edges until
    // out_valid. Returns in the first DONE cycle (#1 after the edge).
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tc, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        check("accept_timeout", (guard < 40), 1);
        a = ta; b = tb_; cin = tc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; cin = $urandom;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    vec_t vecs[10];
    logic [W:0] expq[$];

    initial begin
        int lat;
        int acc;
        int outs;
        int cyc;
        logic [W:0] e;

        vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[7] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[8] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0};
        vecs[9] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready_forced_low", in_ready, 0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", in_ready, 1);

        // ---- basic add with latency ----
        run_op(8'h5A, 8'h33, 1'b0, lat);
        check("basic_latency", lat, W);
        check("basic_sum", sum, 8'h8D);
        check("basic_cout", cout, 0);
        check("basic_in_ready_done", in_ready, 0);
        check("basic_busy_done", busy, 1);
        @(posedge clk); #1;
        check("basic_out_valid_drop", out_valid, 0);
        check("basic_in_ready_back", in_ready, 1);
        check("basic_sum_held", sum, 8'h8D);

        // ---- directed table ----
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, lat);
            check($sformatf("vec%0d_latency", i), lat, W);
            check($sformatf("vec%0d_sum", i), sum, vecs[i].exp_sum);
            check($sformatf("vec%0d_cout", i), cout, vecs[i].exp_cout);
            @(posedge clk); #1;
        end

        // ---- backpressure: result held, new offer ignored ----
        out_ready = 1'b0;
        run_op(8'h10, 8'h20, 1'b0, lat);
        check("bp_latency", lat, W);
        in_valid = 1'b1; a = 8'hAA; b = 8'hAA; cin = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("bp%0d_out_valid", i), out_valid, 1);
            check($sformatf("bp%0d_sum", i), sum, 8'h30);
            check($sformatf("bp%0d_cout", i), cout, 0);
            check($sformatf("bp%0d_in_ready", i), in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_release_out_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_sum_held", sum, 8'h30);

        // ---- reset on the third RUN cycle ----
        in_valid = 1'b1; a = 8'h77; b = 8'h11; cin = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mr_busy_before", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("mr_out_valid", out_valid, 0);
        check("mr_sum", sum, 0);
        check("mr_cout", cout, 0);
        check("mr_busy", busy, 0);
        check("mr_in_ready", in_ready, 1);
        repeat (W + 2) @(posedge clk);
        #1;
        check("mr_no_ghost_result", out_valid, 0);
        run_op(8'h01, 8'h01, 1'b0, lat);
        check("mr_after_latency", lat, W);
        check("mr_after_sum", sum, 8'h02);
        check("mr_after_cout", cout, 0);
        @(posedge clk); #1;

        // ---- randomized regression against integer addition ----
        acc = 0; outs = 0; cyc = 0;
        while ((acc < 500 || expq.size() > 0) && cyc < 30000) begin
            @(negedge clk);
            if (in_valid && in_ready) begin
                expq.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin});
                acc++;
            end
            if (out_valid && out_ready) begin
                outs++;
                if (expq.size() == 0) begin
                    check("rnd_unexpected_output", 1, 0);
                end else begin
                    e = expq.pop_front();
                    check("rnd_result", {cout, sum}, e);
                end
            end
            @(posedge clk); #1;
            in_valid  = (acc < 500) ? ($urandom_range(0, 3) != 0) : 1'b0;
            a         = $urandom;
            b         = $urandom;
            cin       = $urandom;
            out_ready = ($urandom_range(0, 1) == 1);
            cyc++;
        end
        check("rnd_accept_count", acc, 500);
        check("rnd_output_count", outs, acc);
        check("rnd_queue_drained", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_adder
